// File: rtl/placement_pkg.sv
// placement_pkg: shared constants, types and helpers for the strip allocator.
//   STRIP_NUM  - number of horizontal strips on the board
//   BOARD_W    - board width in columns
//   MAX_H      - tallest legal program height
//   STRIKE_MAX - saturation value of the consecutive-reject counter
//   STRIP_H    - strip heights, element 0 is strip ID 1
//   state_t    - allocator FSM states
package placement_pkg;

  localparam int unsigned STRIP_NUM  = 13;
  localparam int unsigned BOARD_W    = 128;
  localparam int unsigned MAX_H      = 16;
  localparam int unsigned STRIKE_MAX = 15;

  localparam logic [4:0] STRIP_H [STRIP_NUM] = '{
    5'd8, 5'd8, 5'd9, 5'd7, 5'd10, 5'd6, 5'd11,
    5'd5, 5'd12, 5'd4, 5'd16, 5'd16, 5'd16
  };

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT,
    DONE
  } state_t;

  // Height of strip `id` (1-based); 0 for an out-of-range ID.
  function automatic logic [4:0] strip_height(input logic [3:0] id);
    logic [4:0] h;
    h = '0;
    for (int unsigned i = 0; i < STRIP_NUM; i++) begin
      if (id == 4'(i + 1)) h = STRIP_H[i];
    end
    return h;
  endfunction

endpackage

// File: rtl/strip_occupancy_array.sv
// strip_occupancy_array: per-strip occupied width, STRIP_NUM x 8-bit.
//   clk, rst      - clock, asynchronous active-high reset
//   i_clear       - synchronous clear of every entry (wins over a write)
//   i_rd_idx      - combinational read index (1-based); o_rd_data = 0 if out of range
//   i_wr_en       - write enable
//   i_wr_idx      - write index (1-based)
//   i_wr_data     - new occupancy value
module strip_occupancy_array
  import placement_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic [3:0] i_rd_idx,
  output logic [7:0] o_rd_data,
  input  logic       i_wr_en,
  input  logic [3:0] i_wr_idx,
  input  logic [7:0] i_wr_data
);

  logic [7:0] r_occ [STRIP_NUM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STRIP_NUM; i++) r_occ[i] <= '0;
    end else if (i_clear) begin
      for (int unsigned i = 0; i < STRIP_NUM; i++) r_occ[i] <= '0;
    end else if (i_wr_en) begin
      for (int unsigned i = 0; i < STRIP_NUM; i++) begin
        if (i_wr_idx == 4'(i + 1)) r_occ[i] <= i_wr_data;
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int unsigned i = 0; i < STRIP_NUM; i++) begin
      if (i_rd_idx == 4'(i + 1)) o_rd_data = r_occ[i];
    end
  end

endmodule

// File: rtl/strip_allocator.sv
// strip_allocator: sequential best-fit placement of a (width, height) program
// request into one of STRIP_NUM fixed-height strips of a 128-column board.
//   clk, rst            - clock, asynchronous active-high reset
//   req_valid_in        - request present
//   req_ready_out       - high in IDLE; request accepted on valid & ready
//   req_width_in        - program width, legal 1..128
//   req_height_in       - program height, legal 1..16
//   clear_in            - synchronous: empty strips, zero strikes, abort request
//   out_valid           - one-cycle result pulse
//   strip_ID_out        - chosen strip 1..13, 0 on reject
//   occupied_width_out  - strip occupancy before placement, 0 on reject
//   strike_out          - 0 on success, saturating consecutive-reject count
module strip_allocator
  import placement_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid_in,
  output logic       req_ready_out,
  input  logic [7:0] req_width_in,
  input  logic [4:0] req_height_in,
  input  logic       clear_in,
  output logic       out_valid,
  output logic [3:0] strip_ID_out,
  output logic [7:0] occupied_width_out,
  output logic [3:0] strike_out
);

  state_t r_state;
  state_t w_next;

  logic [3:0] r_idx;
  logic [7:0] r_width;
  logic [4:0] r_height;
  logic       r_legal;
  logic       r_best_found;
  logic [3:0] r_best_id;
  logic [4:0] r_best_waste;
  logic [7:0] r_best_occ;
  logic [3:0] r_fail_cnt;
  logic [3:0] r_strip_id;
  logic [7:0] r_occ_out;
  logic [3:0] r_strike;

  logic       w_accept;
  logic [7:0] w_occ;
  logic [4:0] w_h;
  logic [8:0] w_sum;
  logic       w_fit;
  logic [4:0] w_waste;
  logic       w_better;
  logic [3:0] w_fail_inc;
  logic       w_wr_en;
  logic [7:0] w_wr_data;

  strip_occupancy_array u_occ (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (clear_in),
    .i_rd_idx (r_idx),
    .o_rd_data(w_occ),
    .i_wr_en  (w_wr_en),
    .i_wr_idx (r_best_id),
    .i_wr_data(w_wr_data)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    if (clear_in) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (req_valid_in) w_next = SCAN;
        SCAN:    if (r_idx == 4'(STRIP_NUM)) w_next = COMMIT;
        COMMIT:  w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // clear_in gates both handshake outputs so a same-cycle request is not taken
  // and a result in DONE is dropped.
  always_comb begin
    req_ready_out = (r_state == IDLE) && !clear_in;
    out_valid     = (r_state == DONE) && !clear_in;
  end

  assign w_accept = req_valid_in && req_ready_out;

  // ---------------- Best-fit evaluation of strip r_idx ----------------
  // Occupancy + width is formed in 9 bits so an oversize width cannot wrap
  // into a false fit. Legality is latched at accept so an illegal request
  // still scans but never fits.
  always_comb begin
    w_h        = strip_height(r_idx);
    w_sum      = {1'b0, w_occ} + {1'b0, r_width};
    w_fit      = r_legal && (w_h >= r_height) && (w_sum <= 9'(BOARD_W));
    w_waste    = w_h - r_height;
    w_better   = w_fit && (!r_best_found || (w_waste < r_best_waste));
    w_fail_inc = (r_fail_cnt == 4'(STRIKE_MAX)) ? r_fail_cnt : r_fail_cnt + 4'd1;
    w_wr_en    = (r_state == COMMIT) && r_best_found && !clear_in;
    w_wr_data  = r_best_occ + r_width;
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= '0;
      r_width      <= '0;
      r_height     <= '0;
      r_legal      <= 1'b0;
      r_best_found <= 1'b0;
      r_best_id    <= '0;
      r_best_waste <= '0;
      r_best_occ   <= '0;
      r_fail_cnt   <= '0;
      r_strip_id   <= '0;
      r_occ_out    <= '0;
      r_strike     <= '0;
    end else if (clear_in) begin
      r_fail_cnt   <= '0;
      r_best_found <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_width      <= req_width_in;
            r_height     <= req_height_in;
            r_legal      <= (req_width_in != '0) && (req_width_in <= 8'(BOARD_W)) &&
                            (req_height_in != '0) && (req_height_in <= 5'(MAX_H));
            r_idx        <= 4'd1;
            r_best_found <= 1'b0;
          end
        end
        SCAN: begin
          if (w_better) begin
            r_best_found <= 1'b1;
            r_best_id    <= r_idx;
            r_best_waste <= w_waste;
            r_best_occ   <= w_occ;
          end
          r_idx <= r_idx + 4'd1;
        end
        COMMIT: begin
          if (r_best_found) begin
            r_strip_id <= r_best_id;
            r_occ_out  <= r_best_occ;
            r_strike   <= '0;
            r_fail_cnt <= '0;
          end else begin
            r_strip_id <= '0;
            r_occ_out  <= '0;
            r_strike   <= w_fail_inc;
            r_fail_cnt <= w_fail_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign strip_ID_out       = r_strip_id;
  assign occupied_width_out = r_occ_out;
  assign strike_out         = r_strike;

endmodule
